// File: rtl/ota_pkg.sv
// Shared types and constants for the OTA comparator stream decimator.
package ota_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM
  } state_t;

  localparam int SAMPLE_W = 8;

  localparam int WINDOW_LOG2_MIN   = 8;
  localparam int WINDOW_LOG2_MAX   = 12;
  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 3;
  localparam int SETTLE_CYCLES_MIN = 1;
  localparam int SETTLE_CYCLES_MAX = 15;

  // Wide enough to count up to the largest legal settle time.
  localparam int SETTLE_CNT_W = $clog2(SETTLE_CYCLES_MAX + 1);

endpackage

// File: rtl/ota_sync.sv
// N-stage two-bit synchroniser for the asynchronous comparator signals.
// Kept as its own module so the synchroniser flops can be constrained as a group.
module ota_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [STAGES-1:0][1:0] chain;

  // Shift both bits through the flop chain, oldest at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the synchroniser flops are reset too, so downstream logic starts from a known 0 instead of X.
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ota_stream_decimator.sv
// Ones-density decimator for the OTA comparator bit-stream: synchronise, hold
// while the comparator is tri-stated, count ones per window, hand out 8-bit samples.
module ota_stream_decimator
  import ota_pkg::*;
#(
  parameter int WINDOW_LOG2   = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ota_out,
  input  logic                ota_en,
  input  logic                run,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                stuck,
  output logic                busy
);

  localparam int ACC_W = WINDOW_LOG2 + 1;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]              sync_q;
  logic                    s_out;
  logic                    s_en;
  logic                    h;
  logic                    h_prev;
  state_t                  state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [WINDOW_LOG2-1:0]  win_cnt;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_final;
  logic                    tog;
  logic                    tog_final;
  logic                    win_last;
  logic [SAMPLE_W-1:0]     scaled;
  logic                    done;
  logic [SAMPLE_W-1:0]     result;
  logic                    result_stuck;

  ota_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({ota_en, ota_out}),
    .q     (sync_q)
  );

  assign s_en  = sync_q[1];
  assign s_out = sync_q[0];

  // Window totals including the bit seen on the current ACCUM cycle; the very
  // first cycle of a window has no predecessor, so it never counts as a toggle.
  assign win_last  = &win_cnt;
  assign acc_final = acc + ACC_W'(h);
  assign tog_final = tog | ((win_cnt != '0) && (h != h_prev));
  // A full window of ones would overflow 8 bits after truncation, so saturate it.
  assign scaled    = acc_final[WINDOW_LOG2] ? {SAMPLE_W{1'b1}}
                                            : acc_final[WINDOW_LOG2-1 -: SAMPLE_W];

  // Hold register: follow the comparator while driven, keep the last value while floating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= 1'b0;
    end else if (s_en) begin
      // NOTE: non-blocking assignments throughout sequential logic, so every flop samples pre-edge values.
      h <= s_out;
    end
  end

  // Acquisition FSM: settle after run rises, then accumulate back-to-back windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      settle_cnt   <= '0;
      win_cnt      <= '0;
      acc          <= '0;
      tog          <= 1'b0;
      h_prev       <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_stuck <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            busy       <= 1'b1;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state   <= ACCUM;
              win_cnt <= '0;
              acc     <= '0;
              tog     <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ACCUM: begin
            h_prev  <= h;
            win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
              acc          <= '0;
              tog          <= 1'b0;
              done         <= 1'b1;
              result       <= scaled;
              result_stuck <= !tog_final;
            end else begin
              acc <= acc_final;
              tog <= tog_final;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-entry output register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      // IDLE with run high only happens on a fresh rise of run.
      if (state == IDLE && run) begin
        overrun <= 1'b0;
      end
      if (done) begin
        if (!sample_valid || sample_ready) begin
          sample       <= result;
          stuck        <= result_stuck;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ota_stream_decimator.sv
// Self-checking bench for ota_stream_decimator: randomised and patterned comparator
// streams checked every cycle against a window-level reference model.
module tb_ota_stream_decimator;

  localparam int W   = 8;
  localparam int N   = 1 << W;
  localparam int S   = 4;
  localparam int LAT = 3;            // sync depth plus the hold register
  localparam int W10 = 10;

  typedef enum {M_ONES, M_ALT, M_LOW64, M_RAND, M_HOLD} mode_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ota_out;
  logic       ota_en;
  logic       run;
  logic       run10;
  logic       sample_ready;
  logic [7:0] sample,  sample10;
  logic       sample_valid, sample10_valid;
  logic       overrun, overrun10;
  logic       stuck, stuck10;
  logic       busy, busy10;

  int checks = 0;
  int errors = 0;

  mode_t mode;
  int    pc;
  logic  rdy_rand;

  // reference model state
  logic       m_held;
  logic       hq[$];
  logic       win[$];
  logic       m_run;
  int         m_el;
  logic       m_pend;
  logic [7:0] m_pend_val;
  logic       m_pend_stuck;
  logic [7:0] m_sample;
  logic       m_valid;
  logic       m_over;
  logic       m_stuck;

  ota_stream_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ota_out      (ota_out),
    .ota_en       (ota_en),
    .run          (run),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .stuck        (stuck),
    .busy         (busy)
  );

  ota_stream_decimator #(.WINDOW_LOG2(W10)) dut10 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ota_out      (ota_out),
    .ota_en       (ota_en),
    .run          (run10),
    .sample       (sample10),
    .sample_valid (sample10_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun10),
    .stuck        (stuck10),
    .busy         (busy10)
  );

  always #5 clk = ~clk;

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      if (errors >= 20) begin
        summary();
        $finish;
      end
    end
  endtask

  function automatic logic [7:0] scale(input int ones);
    if (ones == N) return 8'hFF;
    return 8'(ones >> (W - 8));
  endfunction

  task automatic model_reset();
    m_held = 1'b0;
    hq.delete();
    for (int i = 0; i < LAT; i++) hq.push_back(1'b0);
    win.delete();
    m_run = 1'b0; m_el = 0;
    m_pend = 1'b0; m_pend_val = '0; m_pend_stuck = 1'b0;
    m_sample = '0; m_valid = 1'b0; m_over = 1'b0; m_stuck = 1'b0;
  endtask

  // One clock edge of spec-level behaviour: the bit a window sees is the held
  // comparator value from LAT edges earlier; a window is N consecutive bits.
  task automatic model_step();
    logic used;
    int   ones, trans;
    used = hq.pop_front();
    if (ota_en) m_held = ota_out;
    hq.push_back(m_held);

    if (m_pend) begin
      if (!m_valid || sample_ready) begin
        m_sample = m_pend_val; m_stuck = m_pend_stuck; m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
      end
      m_pend = 1'b0;
    end else if (m_valid && sample_ready) begin
      m_valid = 1'b0;
    end

    if (!run) begin
      m_run = 1'b0;
      win.delete();
    end else if (!m_run) begin
      m_run = 1'b1; m_el = 0; m_over = 1'b0;
      win.delete();
    end else begin
      m_el++;
      if (m_el > S) begin
        win.push_back(used);
        if (win.size() == N) begin
          ones = 0; trans = 0;
          for (int i = 0; i < N; i++) begin
            if (win[i]) ones++;
            if (i > 0 && win[i] != win[i-1]) trans++;
          end
          m_pend = 1'b1; m_pend_val = scale(ones); m_pend_stuck = (trans == 0);
          win.delete();
        end
      end
    end
  endtask

  task automatic gen_inputs();
    case (mode)
      M_ONES:  begin ota_en = 1'b1; ota_out = 1'b1; end
      M_ALT:   begin ota_en = 1'b1; ota_out = pc[0]; end
      M_LOW64: begin ota_en = 1'b1; ota_out = ((pc % 256) >= 64); end
      M_RAND:  begin ota_en = ($urandom_range(0, 3) != 0); ota_out = 1'($urandom); end
      default: begin
        ota_en  = (pc < 10);
        ota_out = (pc < 10) ? 1'b1 : 1'($urandom);
      end
    endcase
    if (rdy_rand) sample_ready = 1'($urandom);
    pc++;
  endtask

  task automatic set_mode(input mode_t m);
    mode = m;
    pc = 0;
  endtask

  task automatic cyc();
    gen_inputs();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("outs", 32'({sample, sample_valid, overrun, stuck, busy}),
          32'({m_sample, m_valid, m_over, m_stuck, m_run}));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!sample_valid && lat < budget);
    check("wait_valid", 32'(sample_valid), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample"}, 32'(sample), 32'd0);
    check({tag, "_valid"},  32'(sample_valid), 32'd0);
    check({tag, "_ovr"},    32'(overrun), 32'd0);
    check({tag, "_stuck"},  32'(stuck), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_w10"},    32'({sample10, sample10_valid, overrun10, stuck10, busy10}), 32'd0);
  endtask

  initial begin
    int         lat;
    logic [7:0] first;

    rst_n = 1'b0; run = 1'b0; run10 = 1'b0; sample_ready = 1'b1;
    ota_en = 1'b0; ota_out = 1'b0; rdy_rand = 1'b0;
    set_mode(M_ONES);
    model_reset();
    cycles(3);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(6);

    // all-ones: first-sample latency, saturation, stuck flag, steady throughput
    run = 1'b1;
    cyc();
    wait_valid(400, lat);
    check("ones_latency", 32'(lat), 32'(1 + S + N));
    check("ones_sample", 32'(sample), 32'd255);
    check("ones_stuck", 32'(stuck), 32'd1);
    wait_valid(300, lat);
    check("steady_period", 32'(lat), 32'(N));

    // alternating bit-stream gives half scale
    set_mode(M_ALT);
    wait_valid(300, lat);
    wait_valid(300, lat);
    wait_valid(300, lat);
    check("alt_sample", 32'(sample), 32'd128);
    check("alt_stuck", 32'(stuck), 32'd0);

    // low for 64 of every 256 bits
    set_mode(M_LOW64);
    wait_valid(300, lat);
    wait_valid(300, lat);
    wait_valid(300, lat);
    check("low64_sample", 32'(sample), 32'd192);
    check("low64_stuck", 32'(stuck), 32'd0);

    // random stream with random backpressure, model-checked every cycle
    set_mode(M_RAND);
    rdy_rand = 1'b1;
    cycles(4 * N + 50);
    rdy_rand = 1'b0;
    sample_ready = 1'b1;

    // overrun: two completions without ready
    run = 1'b0;
    cycles(5);
    sample_ready = 1'b0;
    run = 1'b1;
    cyc();
    wait_valid(400, lat);
    check("ovr_first_latency", 32'(lat), 32'(1 + S + N));
    first = m_sample;
    check("ovr_clear_before", 32'(overrun), 32'd0);
    cycles(N);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_sample_kept", 32'(sample), 32'(first));
    check("ovr_valid_kept", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    cyc();
    check("ovr_accept_drops_valid", 32'(sample_valid), 32'd0);
    wait_valid(300, lat);
    check("ovr_next_period", 32'(lat), 32'(N - 1));
    check("ovr_sticky", 32'(overrun), 32'd1);
    run = 1'b0;
    cyc();
    check("ovr_sticky_run_low", 32'(overrun), 32'd1);
    run = 1'b1;
    cyc();
    check("ovr_cleared_by_run_rise", 32'(overrun), 32'd0);

    // abort mid-window: partial window is discarded, full latency after re-raise
    wait_valid(400, lat);
    cycles(100);
    run = 1'b0;
    cycles(3);
    check("abort_idle", 32'(busy), 32'd0);
    run = 1'b1;
    cyc();
    wait_valid(400, lat);
    check("abort_latency", 32'(lat), 32'(1 + S + N));

    // enable hold: comparator released after 10 cycles, h keeps its 1
    run = 1'b0;
    cycles(3);
    set_mode(M_HOLD);
    run = 1'b1;
    cyc();
    wait_valid(400, lat);
    check("hold_sample", 32'(sample), 32'd255);
    check("hold_stuck", 32'(stuck), 32'd1);

    // asynchronous reset mid-window clears everything at once
    cycles(100);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    run = 1'b0;
    cycles(2);
    rst_n = 1'b1;

    // wider window instance
    set_mode(M_ONES);
    cycles(6);
    run10 = 1'b1;
    cyc();
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!sample10_valid && lat < 1200);
    check("w10_valid", 32'(sample10_valid), 32'd1);
    check("w10_latency", 32'(lat), 32'(1 + S + (1 << W10)));
    check("w10_sample", 32'(sample10), 32'd255);
    check("w10_stuck", 32'(stuck10), 32'd1);
    check("w10_busy", 32'(busy10), 32'd1);

    summary();
    $finish;
  end

endmodule

// File: doc/ota_stream_decimator.md
# ota_stream_decimator

- Downstream consumer of the digital OTA comparator bit-stream.
- Synchronises the asynchronous, tri-statable comparator output and holds its last driven value while the OTA enable is low.
- Counts ones over a fixed power-of-two window and delivers an 8-bit density sample through a valid/ready handshake.
- Flags output overrun and a stuck (non-toggling) comparator per window.

## Interface
- `WINDOW_LOG2`, default 8: window length is 2^WINDOW_LOG2 sampled cycles; legal range 8..12.
- `SYNC_STAGES`, default 2: synchroniser depth; legal range 2..3.
- `SETTLE_CYCLES`, default 4: synchronised samples discarded after `run` rises; legal range 1..15.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low. Asserts immediately; deassertion is synchronised externally.
- `ota_out` in 1: comparator output, asynchronous to `clk`. Meaningful only while `ota_en` is high.
- `ota_en` in 1: comparator drive-enable, asynchronous. Synchronised with the same depth as `ota_out`.
- `run` in 1: level; high = acquire windows continuously.
- `sample` out 8: ones density of the last completed window.
- `sample_valid` out 1: `sample` holds an unconsumed result.
- `sample_ready` in 1: downstream accepts `sample` when both valid and ready are high.
- `overrun` out 1: sticky; a completed window was dropped. Cleared only by reset or the rising edge of `run`.
- `stuck` out 1: the last delivered window contained zero transitions of the held bit.
- `busy` out 1: FSM is not IDLE.

## Operation
- **Synchroniser:** `ota_out` and `ota_en` each pass through `SYNC_STAGES` flops, giving `s_out` and `s_en`.
- **Hold register `h`:**
  - loads `s_out` when `s_en` = 1;
  - holds its value when `s_en` = 0 (models the floating, tri-stated node).
  - Reset value is 0.
- **FSM states:** IDLE, SETTLE, ACCUM.
  - IDLE → SETTLE when `run` = 1. Settle counter cleared. `overrun` cleared on `run` rising.
  - SETTLE: counts `SETTLE_CYCLES` clocks. Then → ACCUM with accumulator, transition counter and window counter cleared.
  - ACCUM: every clock, `acc += h`. `tog` is set if `h` differs from its previous value; the first ACCUM cycle does not count as a transition. The window counter increments.
  - On the 2^WINDOW_LOG2-th ACCUM cycle, the window completes. The next window starts in ACCUM on the following cycle with no gap and no re-settle.
  - `run` = 0 in any state → IDLE on the next clock. A partial window is discarded; `sample`, `sample_valid` and `stuck` keep their values.
- **Accumulator width:** `WINDOW_LOG2`+1 bits. It must hold 2^WINDOW_LOG2 exactly.
- **Scaling at window completion:**
  - if `acc` == 2^WINDOW_LOG2, the result is 255;
  - otherwise the result is `acc[WINDOW_LOG2-1 : WINDOW_LOG2-8]`, i.e. truncation with no rounding.
- **Output register (one entry):**
  - If `sample_valid` = 0, or valid and ready are both high in the completion cycle, load the result and `stuck` = !`tog`, and set `sample_valid`.
  - Otherwise the new result is dropped, the old `sample` is kept, and `overrun` is set.
  - Valid and ready with no completion clears `sample_valid` on the next edge.
- **Reset values:** `sample` = 0, `sample_valid` = 0, `overrun` = 0, `stuck` = 0, `busy` = 0. All counters are 0 and the FSM is in IDLE.

## Timing
- **Input latency:** `SYNC_STAGES` clocks from an `ota_out` edge to `s_out`, plus 1 clock into `h`.
- **First result:** `sample_valid` rises on the clock after the completion edge. From `run` sampled high, that is 1 + `SETTLE_CYCLES` + 2^WINDOW_LOG2 clocks (defaults: 261).
- **Throughput:** one sample per 2^WINDOW_LOG2 clocks in steady state.
- **Handshake:**
  - `sample` and `stuck` are stable while `sample_valid` is high and not yet accepted.
  - `sample_ready` may be held permanently high.
  - Accept and refill in the same edge is legal and is not an overrun.
- **Asynchronous reset mid-window:** all state returns to reset values immediately. No partial sample is emitted.

## Structure
- **Shared package `ota_pkg`:**
  - FSM state enum `{IDLE, SETTLE, ACCUM}`;
  - `SAMPLE_W` = 8;
  - the legal parameter bounds as localparams.
- **Sub-module `ota_sync`:** parameterised N-stage two-bit synchroniser, instantiated once for {`ota_en`, `ota_out`}. Kept separate so the sync flops can be constrained.
- Remaining logic (hold register, FSM, accumulator, output register) lives in the top module.

## Test plan
- **All-ones:** `ota_en` = 1, `ota_out` = 1 constant, defaults, `sample_ready` = 1 → first `sample_valid` 261 clocks after `run`; `sample` = 255, `stuck` = 1.
- **Alternating:** `ota_out` toggles every clock, aligned with the window → `sample` = 128, `stuck` = 0. With `ota_out` low for exactly 64 of 256 cycles → `sample` = 192.
- **Enable hold:** `ota_out` = 1 with `ota_en` = 1 for 10 clocks, then `ota_en` = 0 while `ota_out` toggles randomly for the rest of the window → `h` holds 1; `sample` = 255.
- **Overrun:** `sample_ready` = 0 across two window completions → first `sample` retained; `overrun` = 1 after the second completion. Raise ready → `sample_valid` drops and the next window delivers normally. `overrun` stays 1 until `run` toggles.
- **Abort:** `run` dropped mid-window, then raised → no sample from the partial window; the next sample arrives 261 clocks after the re-raise.
- **Reset mid-window:** `rst_n` pulsed low asynchronously mid-window, plus an `WINDOW_LOG2` = 10 run → all outputs are 0 immediately. With constant 1 input and `WINDOW_LOG2` = 10, the first sample is 255 after 1 + 4 + 1024 clocks.
